zc_measure_ctrl: RTL

ZC_MEASURE_CTRL -- requirements
Module: zc_measure_ctrl

---
 rtl/zc_ctrl_pkg.sv | 34 +++
 rtl/zc_watchdog.sv | 40 ++++
 rtl/zc_measure_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/zc_ctrl_pkg.sv
// Shared types and constants for the zero-crossing measurement controller.
//   state_t     : controller state encoding
//   cfg_t       : run configuration captured on start
//   CAL_MARGIN  : extra calibration samples covering the detector pipeline
package zc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_CAL    = 3'd2,
    ST_SKIP   = 3'd3,
    ST_ACCUM  = 3'd4,
    ST_REPORT = 3'd5
  } state_t;

  localparam int unsigned CAL_MARGIN  = 2;
  localparam int unsigned AVG_LEN_MAX = 16;
  localparam int unsigned ACC_GUARD_W = 16;
  // 2^31 + CAL_MARGIN must fit
  localparam int unsigned CAL_CNT_W   = 34;
  localparam int unsigned BEAT_CNT_W  = AVG_LEN_MAX + 1;

  typedef struct packed {
    logic [4:0] cal_len;
    logic [4:0] avg_len;
    logic [7:0] skip;
  } cfg_t;

  // Averaging lengths above the supported maximum saturate to it.
  function automatic logic [4:0] clamp_avg_len(input logic [4:0] len);
    return (len > 5'(AVG_LEN_MAX)) ? 5'(AVG_LEN_MAX) : len;
  endfunction

endpackage

// File: rtl/zc_watchdog.sv
// Inactivity watchdog: counts enabled clocks since the last restart.
//   clk, reset : clock, async active-high reset
//   restart    : zero the count this cycle (activity seen)
//   enable     : count only while high; cleared otherwise
//   limit      : expiry threshold in clocks, 0 disables
//   expired    : the current clock completes `limit` idle clocks
module zc_watchdog #(
  parameter int unsigned TIMEOUT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 restart,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] cnt;
  logic [TIMEOUT_W-1:0] cnt_base;

  // Restart in the same cycle is seen immediately so activity never expires.
  always_comb begin
    cnt_base = restart ? '0 : cnt;
    expired  = enable && (limit != '0) && (cnt_base >= limit - TIMEOUT_W'(1));
  end

  // Saturating idle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (cnt_base != '1) begin
      cnt <= cnt_base + TIMEOUT_W'(1);
    end else begin
      cnt <= cnt_base;
    end
  end

endmodule

// File: rtl/zc_measure_ctrl.sv
// Measurement controller around a zero-crossing detector: clears and
// calibrates the detector, discards leading periods, averages 2^n periods
// and reports the result on a valid/ready stream, with abort and watchdog.
//   clk, reset             : clock, async active-high reset
//   start, abort           : run control pulses
//   log_cal_len, log_avg_len, skip_cnt, timeout : run configuration
//   samp_tvalid            : detector accepted an input sample
//   zc_clear, zc_init_cal, zc_log_cal_len : detector control
//   p_tdata, p_tvalid      : period stream in (always ready)
//   o_tdata, o_tvalid, o_tready : averaged result stream out
//   busy, err_timeout      : status
module zc_measure_ctrl
  import zc_ctrl_pkg::*;
#(
  parameter int unsigned COUNTER_SIZE = 32,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned TIMEOUT_W    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [4:0]              log_cal_len,
  input  logic [4:0]              log_avg_len,
  input  logic [7:0]              skip_cnt,
  input  logic [TIMEOUT_W-1:0]    timeout,
  input  logic                    samp_tvalid,
  output logic                    zc_clear,
  output logic                    zc_init_cal,
  output logic [31:0]             zc_log_cal_len,
  input  logic [COUNTER_SIZE-1:0] p_tdata,
  input  logic                    p_tvalid,
  output logic [COUNTER_SIZE-1:0] o_tdata,
  output logic                    o_tvalid,
  input  logic                    o_tready,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int unsigned ACC_W = COUNTER_SIZE + ACC_GUARD_W;

  // WIDTH only names the detector sample width; no sample data passes here.
  if (WIDTH == 0) begin : g_no_sample_width
  end

  state_t                  state, next_state, state_d;
  cfg_t                    cfg;
  logic [TIMEOUT_W-1:0]    cfg_timeout;
  logic [CAL_CNT_W-1:0]    cal_cnt;
  logic [7:0]              skip_seen;
  logic [BEAT_CNT_W-1:0]   beat_cnt;
  logic [ACC_W-1:0]        acc;

  logic [ACC_W-1:0]        acc_sum_c;
  logic [CAL_CNT_W-1:0]    cal_target_c;
  logic [BEAT_CNT_W-1:0]   beat_target_c;
  logic                    cal_done_c, skip_done_c, beat_done_c, start_ok_c;
  state_t                  run_entry_c;
  logic                    wd_restart_c, wd_enable_c, wd_expired;
  logic                    clear_d, init_d, busy_d, valid_d, err_d, load_result_c;

  // Watchdog restarts on period activity and on the first cycle of each state.
  assign wd_restart_c = p_tvalid || (state != state_d);
  assign wd_enable_c  = (state == ST_CAL) || (state == ST_SKIP) || (state == ST_ACCUM);

  zc_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .restart (wd_restart_c),
    .enable  (wd_enable_c),
    .limit   (cfg_timeout),
    .expired (wd_expired)
  );

  // Phase completion conditions.
  always_comb begin
    start_ok_c    = start && !abort;
    cal_target_c  = (CAL_CNT_W'(1) << cfg.cal_len) + CAL_CNT_W'(CAL_MARGIN);
    cal_done_c    = samp_tvalid && ((cal_cnt + CAL_CNT_W'(1)) == cal_target_c);
    skip_done_c   = p_tvalid && ((skip_seen + 8'd1) == cfg.skip);
    beat_target_c = BEAT_CNT_W'(1) << cfg.avg_len;
    beat_done_c   = p_tvalid && ((beat_cnt + BEAT_CNT_W'(1)) == beat_target_c);
    acc_sum_c     = acc + ACC_W'(p_tdata);
    run_entry_c   = (cfg.skip == 8'd0) ? ST_ACCUM : ST_SKIP;
  end

  // State register; state_d lets the watchdog see state entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      state_d <= ST_IDLE;
    end else begin
      state   <= next_state;
      state_d <= state;
    end
  end

  // Next state: abort beats timeout beats normal progress.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start) next_state = ST_CLR;
        ST_CLR:    next_state = (cfg.cal_len != 5'd0) ? ST_CAL : run_entry_c;
        ST_CAL: begin
          if (wd_expired)      next_state = ST_IDLE;
          else if (cal_done_c) next_state = run_entry_c;
        end
        ST_SKIP: begin
          if (wd_expired)       next_state = ST_IDLE;
          else if (skip_done_c) next_state = ST_ACCUM;
        end
        ST_ACCUM: begin
          if (wd_expired)       next_state = ST_IDLE;
          else if (beat_done_c) next_state = ST_REPORT;
        end
        ST_REPORT: if (o_tready) next_state = run_entry_c;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  // Output next values, registered below.
  always_comb begin
    clear_d       = 1'b0;
    init_d        = 1'b0;
    busy_d        = 1'b0;
    valid_d       = 1'b0;
    err_d         = err_timeout;
    load_result_c = 1'b0;
    clear_d       = (next_state == ST_CLR);
    init_d        = (next_state == ST_CAL) && (state != ST_CAL);
    busy_d        = (next_state != ST_IDLE);
    valid_d       = (next_state == ST_REPORT);
    load_result_c = (state == ST_ACCUM) && (next_state == ST_REPORT);
    if ((state == ST_IDLE) && start_ok_c) err_d = 1'b0;
    else if (!abort && wd_expired)        err_d = 1'b1;
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zc_clear    <= 1'b0;
      zc_init_cal <= 1'b0;
      busy        <= 1'b0;
      o_tvalid    <= 1'b0;
      err_timeout <= 1'b0;
      o_tdata     <= '0;
    end else begin
      zc_clear    <= clear_d;
      zc_init_cal <= init_d;
      busy        <= busy_d;
      o_tvalid    <= valid_d;
      err_timeout <= err_d;
      if (load_result_c) o_tdata <= COUNTER_SIZE'(acc_sum_c >> cfg.avg_len);
    end
  end

  // Configuration capture and phase counters; every state change clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg            <= '0;
      cfg_timeout    <= '0;
      zc_log_cal_len <= '0;
      cal_cnt        <= '0;
      skip_seen      <= '0;
      beat_cnt       <= '0;
      acc            <= '0;
    end else begin
      if ((state == ST_IDLE) && start_ok_c) begin
        cfg.cal_len    <= log_cal_len;
        cfg.avg_len    <= clamp_avg_len(log_avg_len);
        cfg.skip       <= skip_cnt;
        cfg_timeout    <= timeout;
        zc_log_cal_len <= 32'(log_cal_len);
      end
      if (next_state != state) begin
        cal_cnt   <= '0;
        skip_seen <= '0;
        beat_cnt  <= '0;
        acc       <= '0;
      end else begin
        case (state)
          ST_CAL:   if (samp_tvalid) cal_cnt <= cal_cnt + CAL_CNT_W'(1);
          ST_SKIP:  if (p_tvalid) skip_seen <= skip_seen + 8'd1;
          ST_ACCUM: begin
            if (p_tvalid) begin
              acc      <= acc_sum_c;
              beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
